radix4_booth_multiplier: RTL and testbench
==========================================

RADIX4_BOOTH_MULTIPLIER -- requirements
Module: radix4_booth_multiplier

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the operand width; N SHALL be even and >= 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 The block SHALL have port signedInput, input, 1 bit: 1 = two's-complement operands; 0 = unsigned operands.
REQ-006 The block SHALL have ports x and y, input, N bits each: multiplicand and multiplier.
REQ-007 The block SHALL have port p, output, 2N bits: the registered product.
REQ-008 The block SHALL have port done, output, 1 bit: the result is valid on p.
REQ-009 The block SHALL have port busy, output, 1 bit: an operation is in progress.

Function
REQ-010 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-011 In IDLE with start=1 at a rising edge, the block SHALL capture x, y and signedInput, clear the accumulator, load the iteration counter with N/2+1 and enter RUN.
REQ-012 The block SHALL extend both operands to N+2 bits (sign-extended if signedInput=1, zero-extended otherwise), so unsigned and signed operands share one datapath.
REQ-013 Each RUN cycle SHALL recode one overlapping 3-bit multiplier group into a digit in {-2,-1,0,+1,+2}, add the selected multiple of the multiplicand (shifted-left multiplicand for ±2, two's-complement negation for negative digits) to the accumulator, shift the result right by 2 arithmetically, and decrement the counter.
REQ-014 After exactly N/2+1 RUN cycles the block SHALL load p with the low 2N bits of the exact product and enter DONE; done SHALL rise on that same edge (N=32: 17 edges after the capture edge).
REQ-015 Latency SHALL be fixed and independent of operand values; there SHALL be no early termination on zero digits or zero operands.
REQ-016 p SHALL equal x*y modulo 2^(2N), interpreted as signed when signedInput=1 and as unsigned otherwise; no overflow is possible.
REQ-017 busy SHALL be 1 exactly while in RUN; done SHALL be 1 exactly while in DONE.
REQ-018 DONE SHALL be held while start=1; when start=0 at a rising edge, the block SHALL return to IDLE and done SHALL fall.
REQ-019 p SHALL hold its value through DONE and IDLE and SHALL change only on the edge that enters DONE.
REQ-020 Changes on start, x, y or signedInput during RUN SHALL be ignored.
REQ-021 A start pulse that has already been consumed SHALL NOT retrigger; a new operation requires a pass through IDLE.
REQ-022 Holding start=1 in IDLE on consecutive edges SHALL launch exactly one operation per pass through IDLE.

Reset
REQ-023 While rst=0, the block SHALL asynchronously force state=IDLE, p=0, done=0, busy=0, accumulator=0 and counter=0, without waiting for clk.
REQ-024 Asserting rst mid-RUN or in DONE SHALL abort the operation; after rst returns to 1, the first start SHALL produce a correct result with full latency.

Verification
REQ-025 The bench SHALL cover: N=32, unsigned, x=y=0xFFFFFFFF -> p=0xFFFFFFFE00000001; done rises 17 edges after the capture edge; busy=1 for exactly 17 cycles.
REQ-026 The bench SHALL cover: signed, x=y=0x80000000 -> p=0x4000000000000000.
REQ-027 The bench SHALL cover: x=0xFFFFFFFF, y=0x00000007 -> signed p=0xFFFFFFFFFFFFFFF9 and unsigned p=0x00000006FFFFFFF9.
REQ-028 The bench SHALL cover: rst=0 applied 5 cycles into RUN -> p=0, done=0, busy=0 immediately; a subsequent signed 0xFFFFFFFE*0x00000003 -> p=0xFFFFFFFFFFFFFFFA.
REQ-029 The bench SHALL cover: start held at 1 throughout, with x and y changed during RUN -> result reflects the captured operands, done stays 1 until start=0, then drops one edge later with p unchanged.
REQ-030 The bench SHALL cover: a swept or random loop over both modes against a behavioural x*y model, with x=0 and y=0 included -> p matches on every operation; on mismatch the bench prints the operands and stops.

Source files
------------

// File: rtl/radix4_booth_multiplier.sv
// Purpose : iterative radix-4 Booth multiplier, signed or unsigned N x N -> 2N product.
// Latency : N/2+1 cycles from the capture edge to done (17 for N=32), independent of operand values.
// Backpr. : start is sampled only in IDLE; done and p are held in DONE until start is released.
//
// Ports:
//   clk          - single clock, rising edge
//   rst          - asynchronous active-low reset
//   start        - request an operation (sampled in IDLE, released to leave DONE)
//   signedInput  - 1: two's-complement operands, 0: unsigned operands
//   x, y         - multiplicand, multiplier (N bits each)
//   p            - registered 2N-bit product
//   done         - p holds a valid result (state DONE)
//   busy         - operation in progress (state RUN)
module radix4_booth_multiplier #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           signedInput,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic [2*N-1:0] p,
    output logic           done,
    output logic           busy
);

    // Operands are widened to E bits so an unsigned operand is a positive
    // signed number; the accumulator needs two more bits to hold the
    // running partial sum plus a +/-2M addend without overflow.
    localparam int E   = N + 2;
    localparam int W   = N + 4;
    localparam int NIT = N / 2 + 1;
    localparam int CW  = $clog2(NIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [E-1:0]         mcand;
    logic [E-1:0]         mplier;   // low bits hold the next Booth group; product low half shifts in from the top
    logic                 qm1;      // bit to the right of the current group
    logic signed [W-1:0]  acc;
    logic [CW-1:0]        cnt;

    logic [2:0]           grp;
    logic signed [W-1:0]  m_ext;
    logic signed [W-1:0]  m_x2;
    logic signed [W-1:0]  addend;
    logic signed [W-1:0]  a_sum;
    logic signed [W-1:0]  a_next;
    logic [E-1:0]         q_next;
    logic [2*N-1:0]       prod;

    always_comb begin
        grp    = {mplier[1:0], qm1};
        m_ext  = {{2{mcand[E-1]}}, mcand};
        m_x2   = m_ext <<< 1;
        addend = '0;
        case (grp)
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m_x2;
            3'b100:         addend = -m_x2;
            3'b101, 3'b110: addend = -m_ext;
            default:        addend = '0;
        endcase
        a_sum  = acc + addend;
        a_next = a_sum >>> 2;
        // The two bits shifted out of the accumulator are finished product bits.
        q_next = {a_sum[1:0], mplier[E-1:2]};
        // After the final step {a_next, q_next} is the full product; keep the low 2N bits.
        prod   = {a_next[N-3:0], q_next};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            p      <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            qm1    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // signedInput is folded into the extension here, so
                        // the mode is effectively captured with the operands.
                        mcand  <= {{2{signedInput & x[N-1]}}, x};
                        mplier <= {{2{signedInput & y[N-1]}}, y};
                        qm1    <= 1'b0;
                        acc    <= '0;
                        cnt    <= CW'(NIT);
                        state  <= RUN;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                    end
                end
                RUN: begin
                    acc    <= a_next;
                    mplier <= q_next;
                    qm1    <= mplier[1];
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        p     <= prod;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    // A held start keeps the result presented; a new operation
                    // needs start low for at least one edge to pass through IDLE.
                    if (!start) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_radix4_booth_multiplier.sv
// Purpose : self-checking bench for radix4_booth_multiplier (N=32).
// Latency : checks done 17 edges after capture and busy high for 17 cycles.
// Backpr. : exercises start held through DONE and release back to IDLE.
module tb_radix4_booth_multiplier;

    localparam int N = 32;

    logic           clk;
    logic           rst;
    logic           start;
    logic           signedInput;
    logic [N-1:0]   x;
    logic [N-1:0]   y;
    logic [2*N-1:0] p;
    logic           done;
    logic           busy;

    int tests;
    int failed;

    logic [2*N-1:0] sb[$];

    radix4_booth_multiplier #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signedInput (signedInput),
        .x           (x),
        .y           (y),
        .p           (p),
        .done        (done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic           s;
        logic [2*N-1:0] exp;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [2*N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        logic [2*N-1:0] ea;
        logic [2*N-1:0] eb;
        ea = s ? {{N{a[N-1]}}, a} : {{N{1'b0}}, a};
        eb = s ? {{N{b[N-1]}}, b} : {{N{1'b0}}, b};
        return ea * eb;
    endfunction

    task automatic check(input string name, input logic [2*N-1:0] act, input logic [2*N-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one operation, pushes its expectation, waits (bounded) for done
    // and compares the popped expectation against p plus the timing.
    // hold=1 keeps start high through RUN and perturbs the inputs mid-run.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                         input logic [2*N-1:0] exp, input bit hold, output logic [2*N-1:0] got_exp);
        int lat;
        int bcnt;
        @(negedge clk);
        x = a;
        y = b;
        signedInput = s;
        start = 1'b1;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        bcnt = busy ? 1 : 0;
        lat = 0;
        if (!hold) start = 1'b0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
            if (hold && lat == 3) begin
                x = $urandom;
                y = $urandom;
                signedInput = ~signedInput;
            end
        end
        check("done_seen", {63'd0, done}, 64'd1);
        check("latency", 64'(lat), 64'd17);
        check("busy_cycles", 64'(bcnt), 64'd17);
        got_exp = sb.pop_front();
        check("product", p, got_exp);
        if (!hold) begin
            @(posedge clk);
            #1;
            check("done_fall", {63'd0, done}, 64'd0);
            check("p_hold_idle", p, got_exp);
        end
    endtask

    initial begin
        logic [2*N-1:0] e;
        logic [N-1:0]   ra;
        logic [N-1:0]   rb;
        logic           rs;
        int             f0;

        tests  = 0;
        failed = 0;
        rst = 1'b0;
        start = 1'b0;
        signedInput = 1'b0;
        x = '0;
        y = '0;

        vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
        vecs[1] = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
        vecs[2] = '{32'hFFFFFFFF, 32'h00000007, 1'b1, 64'hFFFFFFFFFFFFFFF9};
        vecs[3] = '{32'hFFFFFFFF, 32'h00000007, 1'b0, 64'h00000006FFFFFFF9};
        vecs[4] = '{32'h00000000, 32'h12345678, 1'b1, 64'h0000000000000000};
        vecs[5] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC000000080000000};

        #12;
        check("reset_p", p, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, 1'b0, e);
        end

        // Reset five cycles into RUN: outputs clear without a clock edge.
        @(negedge clk);
        x = 32'h12345678;
        y = 32'h9ABCDEF0;
        signedInput = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_run_busy", {63'd0, busy}, 64'd1);
        rst = 1'b0;
        #1;
        check("abort_p", p, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        do_op(32'hFFFFFFFE, 32'h00000003, 1'b1, 64'hFFFFFFFFFFFFFFFA, 1'b0, e);

        // Start held throughout, inputs disturbed during RUN.
        do_op(32'h0000ABCD, 32'hFFFF0001, 1'b0, 64'h0000ABCC5433ABCD, 1'b1, e);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("hold_done", {63'd0, done}, 64'd1);
            check("hold_p", p, e);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        check("release_done", {63'd0, done}, 64'd0);
        check("release_p", p, e);

        // Random sweep over both modes; zero operands forced on a few slots.
        for (int k = 0; k < 40; k++) begin
            ra = $urandom;
            rb = $urandom;
            rs = k[0];
            if (k == 2 || k == 3) ra = '0;
            if (k == 4 || k == 5) rb = '0;
            f0 = failed;
            do_op(ra, rb, rs, model(ra, rb, rs), 1'b0, e);
            if (failed != f0) begin
                $display("FAIL random_op: x=0x%0h y=0x%0h signed=%0d got 0x%0h expected 0x%0h",
                         ra, rb, rs, p, e);
                break;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
